row_col_dec: RTL



---
 rtl/row_col_dec.sv | 92 +++++++++
 1 files changed

// File: rtl/row_col_dec.sv
// row_col_dec: decodes the DCO row/column unit-cap selector code back to its binary tuning word.
// Two registered stages, per-sample illegal-code flagging, sticky flag and saturating error counter.
module row_col_dec #(
   parameter int WORD_W = 8,
   parameter int ROW_W  = 4,
   parameter int CNT_W  = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    in_vld,
   input  logic [(1<<ROW_W)-1:0]   r_all,
   input  logic [(1<<ROW_W)-1:0]   row,
   input  logic [(1<<ROW_W)-1:0]   col,
   input  logic                    err_clr,
   output logic [WORD_W-1:0]       word,
   output logic                    out_vld,
   output logic                    err,
   output logic                    err_sticky,
   output logic [CNT_W-1:0]        err_cnt
);
   localparam int SIZE = 1 << ROW_W;
   localparam logic [SIZE:0] ONE = (SIZE+1)'(1);

   logic [SIZE-1:0]   ra_q, ra_d, rw_q, rw_d, cl_q, cl_d;
   logic              v1_q, v1_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic              out_vld_q, out_vld_d, err_q, err_d, sticky_q, sticky_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_base;
   logic [ROW_W:0]    k, c;
   logic [SIZE-1:0]   th_k, th_c, col_rev;
   logic              legal, idle, dec, bad;

   always_comb begin
      k       = '0;
      c       = '0;
      col_rev = '0;
      for (int i = 0; i < SIZE; i++) begin
         k          = k + {{ROW_W{1'b0}}, ra_q[i]};
         c          = c + {{ROW_W{1'b0}}, cl_q[i]};
         col_rev[i] = cl_q[SIZE-1-i];
      end
      th_k  = SIZE'((ONE << k) - ONE);
      th_c  = SIZE'((ONE << c) - ONE);
      // odd rows fill from the MSB, so the bit-reversed column must be a plain thermometer
      legal = (ra_q == th_k) && (k < (ROW_W+1)'(SIZE)) && (rw_q == SIZE'(ONE << k)) &&
              (c < (ROW_W+1)'(SIZE)) && ((k[0] ? col_rev : cl_q) == th_c);
      idle  = ~|{ra_q, rw_q, cl_q};
      dec   = en & v1_q;
      bad   = dec & ~(legal | idle);
      v1_d  = en ? in_vld : v1_q;
      ra_d  = (en & in_vld) ? r_all : ra_q;
      rw_d  = (en & in_vld) ? row : rw_q;
      cl_d  = (en & in_vld) ? col : cl_q;
      word_d    = (dec & legal) ? WORD_W'({k[ROW_W-1:0], c[ROW_W-1:0]}) : (dec & idle) ? '0 : word_q;
      out_vld_d = dec;
      err_d     = dec ? bad : en ? 1'b0 : err_q;
      cnt_base  = err_clr ? '0 : cnt_q;
      cnt_d     = (bad & ~&cnt_base) ? cnt_base + 1'b1 : cnt_base;
      sticky_d  = (sticky_q & ~err_clr) | bad;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ra_q      <= '0;
         rw_q      <= '0;
         cl_q      <= '0;
         v1_q      <= 1'b0;
         word_q    <= '0;
         out_vld_q <= 1'b0;
         err_q     <= 1'b0;
         sticky_q  <= 1'b0;
         cnt_q     <= '0;
      end else begin
         ra_q      <= ra_d;
         rw_q      <= rw_d;
         cl_q      <= cl_d;
         v1_q      <= v1_d;
         word_q    <= word_d;
         out_vld_q <= out_vld_d;
         err_q     <= err_d;
         sticky_q  <= sticky_d;
         cnt_q     <= cnt_d;
      end
   end

   assign word       = word_q;
   assign out_vld    = out_vld_q;
   assign err        = err_q & out_vld_q;
   assign err_sticky = sticky_q;
   assign err_cnt    = cnt_q;
endmodule
